// File: rtl/commit_unit_pkg.sv
// Shared retirement-side types and sizing constants.
package System_Pkg;

   localparam int ARCH_REGS = 32;
   localparam int PHY_REGS  = 64;
   localparam int PHY_W     = $clog2(PHY_REGS);
   localparam int ARCH_W    = $clog2(ARCH_REGS);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FLUSH   = 2'd1,
      RECOVER = 2'd2
   } Commit_State_t;

   // Release port toward the free list.
   typedef struct packed {
      logic [PHY_W-1:0] Phy;
      logic             Valid;
   } Free_Port_t;

endpackage

// File: rtl/commit_unit_rrat_array.sv
// Retirement RAT: identity on reset, one write port, two combinational reads.
module rrat_array
   import System_Pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Wr_En,
   input  logic [ARCH_W-1:0] Wr_Arch,
   input  logic [PHY_W-1:0]  Wr_Phy,
   input  logic [ARCH_W-1:0] Rd_Arch_A,
   output logic [PHY_W-1:0]  Rd_Phy_A,
   input  logic [ARCH_W-1:0] Rd_Arch_B,
   output logic [PHY_W-1:0]  Rd_Phy_B
);

   logic [ARCH_REGS-1:0][PHY_W-1:0] rrat_q, rrat_d;

   // Apply the single write; entry 0 is hard-wired and never renamed.
   always_comb begin
      rrat_d = rrat_q;
      if (Wr_En && (Wr_Arch != '0)) rrat_d[Wr_Arch] = Wr_Phy;
   end

   // Table state, reset to the identity mapping.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < ARCH_REGS; i++) rrat_q[i] <= PHY_W'(i);
      end else begin
         rrat_q <= rrat_d;
      end
   end

   // Reads come from the flops, so a commit sees the previous edge's write.
   assign Rd_Phy_A = rrat_q[Rd_Arch_A];
   assign Rd_Phy_B = rrat_q[Rd_Arch_B];

endmodule

// File: rtl/commit_unit.sv
// Retirement stage: pops the ROB head, maintains the RRAT, frees superseded
// physical registers, and on a branch redirect flushes then replays the RRAT.
module commit_unit
   import System_Pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Head_Valid,
   input  logic [ARCH_W-1:0] Head_Rdst,
   input  logic [PHY_W-1:0]  Head_Phydst,
   input  logic [31:0]       Head_PC,
   input  logic              Head_Branch,
   input  logic [31:0]       Head_Branch_To_PC,
   output logic              Check_Commit,
   output logic              Flush,
   output logic              Redirect_Valid,
   output logic [31:0]       Redirect_PC,
   output logic              Free_Valid,
   output logic [PHY_W-1:0]  Free_Phy,
   output logic              Recover_Valid,
   output logic [ARCH_W-1:0] Recover_Arch,
   output logic [PHY_W-1:0]  Recover_Phy,
   output logic              Busy,
   output logic [31:0]       Last_Commit_PC,
   output logic [31:0]       Commit_Count
);

   Commit_State_t     state_q, state_d;
   logic [ARCH_W-1:0] idx_q, idx_d;
   Free_Port_t        free_q, free_d;
   logic [31:0]       redirect_pc_q, redirect_pc_d;
   logic [31:0]       last_pc_q, last_pc_d;
   logic [31:0]       count_q, count_d;
   logic              rrat_we;
   logic [PHY_W-1:0]  old_phy;

   assign Check_Commit = Head_Valid && (state_q == RUN);
   assign rrat_we      = Check_Commit && (Head_Rdst != '0);

   rrat_array u_rrat (
      .Clk       (Clk),
      .Rst       (Rst),
      .Wr_En     (rrat_we),
      .Wr_Arch   (Head_Rdst),
      .Wr_Phy    (Head_Phydst),
      .Rd_Arch_A (Head_Rdst),
      .Rd_Phy_A  (old_phy),
      .Rd_Arch_B (idx_q),
      .Rd_Phy_B  (Recover_Phy)
   );

   // Next-state: FSM sequencing, free pulse, commit bookkeeping.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      free_d.Phy    = free_q.Phy;
      free_d.Valid  = 1'b0;
      redirect_pc_d = redirect_pc_q;
      last_pc_d     = last_pc_q;
      count_d       = count_q;

      if (rrat_we) begin
         free_d.Phy   = old_phy;
         free_d.Valid = 1'b1;
      end
      if (Check_Commit) begin
         count_d   = count_q + 32'd1;
         last_pc_d = Head_PC;
      end

      case (state_q)
         RUN: begin
            if (Check_Commit && Head_Branch) begin
               redirect_pc_d = Head_Branch_To_PC;
               state_d       = FLUSH;
            end
         end
         FLUSH: begin
            idx_d   = '0;
            state_d = RECOVER;
         end
         RECOVER: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == ARCH_W'(ARCH_REGS - 1)) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // State and output registers; reset abandons any recovery in progress.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q       <= RUN;
         idx_q         <= '0;
         free_q        <= '0;
         redirect_pc_q <= '0;
         last_pc_q     <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         free_q        <= free_d;
         redirect_pc_q <= redirect_pc_d;
         last_pc_q     <= last_pc_d;
         count_q       <= count_d;
      end
   end

   assign Flush          = (state_q == FLUSH);
   assign Redirect_Valid = (state_q == FLUSH);
   assign Redirect_PC    = redirect_pc_q;
   assign Free_Valid     = free_q.Valid;
   assign Free_Phy       = free_q.Phy;
   assign Recover_Valid  = (state_q == RECOVER);
   assign Recover_Arch   = idx_q;
   assign Busy           = (state_q != RUN);
   assign Last_Commit_PC = last_pc_q;
   assign Commit_Count   = count_q;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: reset, commits, same-register chains,
// r0 commits, branch flush/replay, and reset during recovery.
module tb_commit_unit;
   import System_Pkg::*;

   logic              Clk, Rst;
   logic              Head_Valid, Head_Branch;
   logic [ARCH_W-1:0] Head_Rdst;
   logic [PHY_W-1:0]  Head_Phydst;
   logic [31:0]       Head_PC, Head_Branch_To_PC;
   logic              Check_Commit, Flush, Redirect_Valid, Free_Valid;
   logic              Recover_Valid, Busy;
   logic [31:0]       Redirect_PC, Last_Commit_PC, Commit_Count;
   logic [PHY_W-1:0]  Free_Phy, Recover_Phy;
   logic [ARCH_W-1:0] Recover_Arch;

   int checks = 0;
   int errors = 0;

   commit_unit dut (
      .Clk               (Clk),
      .Rst               (Rst),
      .Head_Valid        (Head_Valid),
      .Head_Rdst         (Head_Rdst),
      .Head_Phydst       (Head_Phydst),
      .Head_PC           (Head_PC),
      .Head_Branch       (Head_Branch),
      .Head_Branch_To_PC (Head_Branch_To_PC),
      .Check_Commit      (Check_Commit),
      .Flush             (Flush),
      .Redirect_Valid    (Redirect_Valid),
      .Redirect_PC       (Redirect_PC),
      .Free_Valid        (Free_Valid),
      .Free_Phy          (Free_Phy),
      .Recover_Valid     (Recover_Valid),
      .Recover_Arch      (Recover_Arch),
      .Recover_Phy       (Recover_Phy),
      .Busy              (Busy),
      .Last_Commit_PC    (Last_Commit_PC),
      .Commit_Count      (Commit_Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit past the next rising edge.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic br, input int rd, input int phy,
                        input logic [31:0] pc, input logic [31:0] tgt);
      Head_Valid        = v;
      Head_Branch       = br;
      Head_Rdst         = ARCH_W'(rd);
      Head_Phydst       = PHY_W'(phy);
      Head_PC           = pc;
      Head_Branch_To_PC = tgt;
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},    32'(Busy), 0);
      check({tag, "_recv"},    32'(Recover_Valid), 0);
      check({tag, "_flush"},   32'(Flush), 0);
      check({tag, "_redir_v"}, 32'(Redirect_Valid), 0);
   endtask

   initial begin
      logic [31:0] exp_phy;
      Rst = 1'b0;
      drive(0, 0, 0, 0, 32'h0, 32'h0);

      // Reset state
      step();
      step();
      check("rst_cc",      32'(Check_Commit), 0);
      check("rst_free_v",  32'(Free_Valid), 0);
      check("rst_free_p",  32'(Free_Phy), 0);
      check("rst_redir",   Redirect_PC, 0);
      check("rst_lastpc",  Last_Commit_PC, 0);
      check("rst_count",   Commit_Count, 0);
      check("rst_rec_a",   32'(Recover_Arch), 0);
      check_idle("rst");
      Rst = 1'b1;
      step();
      check_idle("rel");

      // Branch on r0: replay must show the identity table
      drive(1, 1, 0, 9, 32'h10, 32'h80);
      check("br0_cc", 32'(Check_Commit), 1);
      step();
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      check("br0_flush",   32'(Flush), 1);
      check("br0_redir_v", 32'(Redirect_Valid), 1);
      check("br0_redir",   Redirect_PC, 32'h80);
      check("br0_busy",    32'(Busy), 1);
      check("br0_free_v",  32'(Free_Valid), 0);
      check("br0_count",   Commit_Count, 1);
      check("br0_lastpc",  Last_Commit_PC, 32'h10);
      step();
      for (int i = 0; i < ARCH_REGS; i++) begin
         check("id_rec_v", 32'(Recover_Valid), 1);
         check("id_rec_a", 32'(Recover_Arch), i);
         check("id_rec_p", 32'(Recover_Phy), i);
         step();
      end
      check_idle("br0_done");

      // Commit r3 <- p40, then r3 <- p41 back to back
      drive(1, 0, 3, 40, 32'h100, 32'h0);
      check("c1_cc", 32'(Check_Commit), 1);
      step();
      drive(1, 0, 3, 41, 32'h104, 32'h0);
      check("c1_free_v",  32'(Free_Valid), 1);
      check("c1_free_p",  32'(Free_Phy), 3);
      check("c1_count",   Commit_Count, 2);
      check("c1_lastpc",  Last_Commit_PC, 32'h100);
      check("c2_cc",      32'(Check_Commit), 1);
      step();
      // Commit r0 <- p50: retires but frees nothing
      drive(1, 0, 0, 50, 32'h108, 32'h0);
      check("c2_free_v",  32'(Free_Valid), 1);
      check("c2_free_p",  32'(Free_Phy), 40);
      check("c2_count",   Commit_Count, 3);
      check("r0_cc",      32'(Check_Commit), 1);
      step();
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      check("r0_free_v",  32'(Free_Valid), 0);
      check("r0_count",   Commit_Count, 4);
      check("r0_lastpc",  Last_Commit_PC, 32'h108);
      check("idle_cc",    32'(Check_Commit), 0);
      step();
      check("idle_free_v", 32'(Free_Valid), 0);
      check("idle_count",  Commit_Count, 4);

      // Branch r31 <- p60 to 0x200, Head_Valid held high through recovery
      drive(1, 1, 31, 60, 32'h10C, 32'h200);
      check("br1_cc", 32'(Check_Commit), 1);
      step();
      drive(1, 0, 7, 33, 32'h110, 32'h0);
      check("br1_flush",   32'(Flush), 1);
      check("br1_redir_v", 32'(Redirect_Valid), 1);
      check("br1_redir",   Redirect_PC, 32'h200);
      check("br1_busy",    32'(Busy), 1);
      check("br1_cc_blk",  32'(Check_Commit), 0);
      check("br1_free_v",  32'(Free_Valid), 1);
      check("br1_free_p",  32'(Free_Phy), 31);
      check("br1_count",   Commit_Count, 5);
      step();
      for (int i = 0; i < ARCH_REGS; i++) begin
         exp_phy = (i == 3) ? 32'd41 : (i == 31) ? 32'd60 : 32'(i);
         check("rec_v",    32'(Recover_Valid), 1);
         check("rec_a",    32'(Recover_Arch), i);
         check("rec_p",    32'(Recover_Phy), exp_phy);
         check("rec_busy", 32'(Busy), 1);
         check("rec_cc",   32'(Check_Commit), 0);
         check("rec_fl",   32'(Flush), 0);
         step();
      end
      // Cycle 34 after the branch commit: dispatch released
      check_idle("br1_done");
      check("br1_cc_run",  32'(Check_Commit), 1);
      check("br1_cnt_end", Commit_Count, 5);
      check("br1_redir_h", Redirect_PC, 32'h200);
      drive(0, 0, 0, 0, 32'h0, 32'h0);

      // Reset asserted at recover index 10
      drive(1, 1, 0, 0, 32'h120, 32'h300);
      step();
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      step();
      repeat (10) step();
      check("mid_rec_a", 32'(Recover_Arch), 10);
      check("mid_rec_v", 32'(Recover_Valid), 1);
      Rst = 1'b0;
      #1;
      check_idle("arst");
      check("arst_count", Commit_Count, 0);
      check("arst_redir", Redirect_PC, 0);
      #2;
      Rst = 1'b1;
      step();
      check_idle("arst_rel");

      // Replay again: table must be identity after the reset
      drive(1, 1, 0, 0, 32'h130, 32'h400);
      step();
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      check("br2_count", Commit_Count, 1);
      step();
      for (int i = 0; i < ARCH_REGS; i++) begin
         check("id2_rec_a", 32'(Recover_Arch), i);
         check("id2_rec_p", 32'(Recover_Phy), i);
         step();
      end
      check_idle("br2_done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
